instr_mem_responder: RTL and testbench
======================================

# instr_mem_responder

Multi-cycle instruction-memory responder serving fetch requests from the CPU's PC stage over a req/ready + valid/ack handshake. Holds a word-addressed program store, accepts one fetch at a time, returns the instruction after a programmable number of wait cycles, and flags misaligned or out-of-range fetches. A side load port fills the store before and during execution. It replaces the combinational instruction memory so the CPU can be tested against realistic fetch latency.

## Interface
- DEPTH, 256: number of 32-bit words in the store (power of two, 4..4096)
- LATENCY, 2: wait cycles between request acceptance and response (0..15)

- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- req_i  in  1  fetch request from CPU
- addr_i  in  32  fetch byte address, sampled on acceptance
- ready_o  out  1  responder idle, request accepted this cycle if req_i high
- valid_o  out  1  response valid, held until ack_i
- instr_o  out  32  fetched instruction, valid while valid_o
- err_o  out  1  fetch error, valid while valid_o
- ack_i  in  1  CPU consumes response
- load_we_i  in  1  program-load write enable
- load_addr_i  in  log2(DEPTH)  program-load word index
- load_data_i  in  32  program-load data

## Operation
- States: IDLE, WAIT, RESP. All outputs registered or decoded from state only; no combinational path input->output.
- IDLE: ready_o=1. req_i=1 -> latch addr_i, load wait counter with LATENCY; go WAIT if LATENCY>0, else RESP. req_i=0 -> stay.
- WAIT: ready_o=0; counter decrements each cycle; leave to RESP on the edge where counter reaches 0 (exactly LATENCY cycles spent in WAIT).
- Entering RESP: instr_o and err_o captured at the same edge; valid_o=1.
- RESP: valid_o, instr_o, err_o stable until ack_i=1; at that edge -> IDLE, valid_o=0, instr_o keeps last value.
- Error: latched addr[1:0]!=0 or addr[31:2]>=DEPTH -> err_o=1, instr_o=32'h0. Otherwise err_o=0, instr_o=store[addr[log2(DEPTH)+1:2]].
- req_i while not ready_o: ignored, no queueing; CPU must hold or reissue.
- ack_i outside RESP: ignored.
- Load port: load_we_i=1 writes load_data_i to store[load_addr_i] at the edge, in every state, including during reset.
- Same-edge read capture and load write to the same word: capture returns OLD contents (read-before-write); the new value is visible to later fetches.
- Store contents are not cleared by reset.

## Timing
- Reset values (edge with rst_i=1): state=IDLE, ready_o=1, valid_o=0, err_o=0, instr_o=0, counter=0.
- Reset mid-fetch (WAIT or RESP): fetch dropped, no valid_o pulse, ready_o=1 the cycle after reset.
- Request accepted at edge T (req_i & ready_o): ready_o=0 from T+1, valid_o=1 from T+1+LATENCY.
- Response with ack_i=1 first sampled at edge A: valid_o=0 and ready_o=1 from A+1; next request accepted at earliest A+1.
- Minimum fetch period with ack_i tied high: LATENCY+2 cycles.
- LATENCY=0: valid_o the cycle after acceptance; WAIT never entered.
- Counter width 4 bits; no wrap since it loads LATENCY and stops at 0.

## Test plan
- Load store[0..3]=32'h20010005, 32'h20020007, 32'h00221820, 32'hAC030000; LATENCY=2, fetch addr 0x8 with ack_i held high -> valid_o=1 at T+3 with instr_o=32'h00221820, err_o=0, ready_o=1 at T+4.
- Fetch addr 0x6 -> valid_o at T+3 with err_o=1, instr_o=0; fetch addr 4*DEPTH (0x400 at DEPTH=256) -> err_o=1, instr_o=0.
- Hold ack_i=0 for 5 cycles in RESP -> valid_o/instr_o stable throughout; req_i=1 during this time ignored (ready_o=0); ack_i=1 -> IDLE next cycle.
- Load write store[1]=32'hDEADBEEF on the same edge a fetch of 0x4 enters RESP -> instr_o=32'h20020007; next fetch of 0x4 -> 32'hDEADBEEF.
- Assert rst_i one cycle during WAIT -> no valid_o, ready_o=1, valid_o=0, instr_o=0 the following cycle; new fetch of 0x0 returns 32'h20010005 with normal latency.
- Rebuild with LATENCY=0, ack_i tied high, req_i tied high -> one response every 2 cycles, addresses 0x0,0x4 returned in order.

Source files
------------

// File: rtl/instr_mem_responder_if.sv
// rtl/instr_mem_responder_if.sv - fetch handshake bundle between the PC stage and the instruction responder
interface instr_mem_responder_if;
  logic        req_i;
  logic [31:0] addr_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] instr_o;
  logic        err_o;
  logic        ack_i;

  // CPU side: issues requests and acknowledges responses
  modport master (
    output req_i, addr_i, ack_i,
    input  ready_o, valid_o, instr_o, err_o
  );

  // Responder side
  modport slave (
    input  req_i, addr_i, ack_i,
    output ready_o, valid_o, instr_o, err_o
  );
endinterface

// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - multi-cycle instruction memory with programmable fetch latency and side load port
module instr_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  instr_mem_responder_if.slave     bus,
  input  logic                     load_we_i,
  input  logic [$clog2(DEPTH)-1:0] load_addr_i,
  input  logic [31:0]              load_data_i
);

  localparam int         AW  = $clog2(DEPTH);
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;
  logic [31:0] addr_q;
  logic [31:0] instr_q;
  logic        err_q;

  logic        latch_addr;
  logic        capture;
  logic [31:0] fetch_addr;
  logic        fetch_err;
  logic [AW-1:0] fetch_idx;

  logic [31:0] mem [DEPTH];

  // Next-state and control decode; the fetch address comes straight from the
  // bus only for the zero-latency path, otherwise from the latched copy
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latch_addr = 1'b0;
    capture    = 1'b0;
    fetch_addr = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_i) begin
          latch_addr = 1'b1;
          fetch_addr = bus.addr_i;
          if (LAT == 4'd0) begin
            state_d = ST_RESP;
            cnt_d   = 4'd0;
            capture = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = LAT;
          end
        end
      end
      ST_WAIT: begin
        // leaving on the edge where the counter hits zero keeps exactly
        // LATENCY cycles in WAIT
        if (cnt_q <= 4'd1) begin
          state_d = ST_RESP;
          cnt_d   = 4'd0;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.ack_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Misaligned or beyond-the-store fetches report an error instead of data
  always_comb begin
    fetch_err = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:AW+2] != '0);
    fetch_idx = fetch_addr[AW+1:2];
  end

  // State, wait counter and accepted address
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_addr) begin
        addr_q <= bus.addr_i;
      end
    end
  end

  // Response capture on entry to RESP; reads the pre-edge store contents so a
  // same-edge load write is only seen by later fetches
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (capture) begin
      err_q   <= fetch_err;
      instr_q <= fetch_err ? 32'h0 : mem[fetch_idx];
    end
  end

  // Program store load port; active in every state and through reset
  always_ff @(posedge clk_i) begin
    if (load_we_i) begin
      mem[load_addr_i] <= load_data_i;
    end
  end

  assign bus.ready_o = (state_q == ST_IDLE);
  assign bus.valid_o = (state_q == ST_RESP);
  assign bus.instr_o = instr_q;
  assign bus.err_o   = err_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// tb/tb_instr_mem_responder.sv - self-checking bench for instr_mem_responder
module tb_instr_mem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_we;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic [29:0] acc1;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] prog  [4];
  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  instr_mem_responder_if bus0();
  instr_mem_responder_if bus1();

  instr_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus0),
    .load_we_i   (load_we),
    .load_addr_i (load_addr),
    .load_data_i (load_data)
  );

  instr_mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut_lat0 (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus1),
    .load_we_i   (load_we),
    .load_addr_i (load_addr),
    .load_data_i (load_data)
  );

  // zero-latency instance: request and ack tied high, address walks 0x0, 0x4, ...
  assign bus1.req_i  = 1'b1;
  assign bus1.ack_i  = 1'b1;
  assign bus1.addr_i = {acc1, 2'b00};

  always @(posedge clk) begin
    if (rst) acc1 <= '0;
    else if (bus1.ready_o) acc1 <= acc1 + 30'd1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_err(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= DEPTH);
  endfunction

  function automatic logic [31:0] ref_instr(input logic [31:0] a);
    if (ref_err(a)) return 32'h0;
    return mem_m[int'(a / 4)];
  endfunction

  // One complete fetch on the LATENCY=2 instance; hold = cycles ack stays low in RESP
  task automatic fetch(input logic [31:0] a, input int hold);
    logic [31:0] exp_instr;
    logic        exp_err;
    int          cycles;
    logic [7:0]  la;
    logic [31:0] ld;
    exp_instr = ref_instr(a);
    exp_err   = ref_err(a);
    chk("pre_ready", bus0.ready_o, 1'b1);
    bus0.req_i  = 1'b1;
    bus0.addr_i = a;
    bus0.ack_i  = 1'b1;
    tick;
    bus0.req_i  = 1'b0;
    bus0.addr_i = $urandom;
    chk("accept_ready_low", bus0.ready_o, 1'b0);
    cycles = 0;
    while (bus0.valid_o !== 1'b1 && cycles < 40) begin
      tick;
      cycles++;
    end
    chk("latency", 32'(cycles), 32'(LAT));
    chk("resp_instr", bus0.instr_o, exp_instr);
    chk("resp_err", bus0.err_o, exp_err);
    bus0.ack_i = (hold == 0);
    for (int h = 0; h < hold; h++) begin
      bus0.req_i  = 1'b1;
      bus0.addr_i = $urandom;
      if ($urandom_range(1) == 1) begin
        la = 8'($urandom_range(DEPTH - 1));
        ld = $urandom;
        load_we = 1'b1; load_addr = la; load_data = ld;
        tick;
        load_we = 1'b0;
        mem_m[la] = ld;
      end else begin
        tick;
      end
      chk("hold_valid", bus0.valid_o, 1'b1);
      chk("hold_instr", bus0.instr_o, exp_instr);
      chk("hold_ready", bus0.ready_o, 1'b0);
    end
    bus0.req_i = 1'b0;
    bus0.ack_i = 1'b1;
    tick;
    bus0.ack_i = 1'b0;
    chk("ack_valid_low", bus0.valid_o, 1'b0);
    chk("ack_ready", bus0.ready_o, 1'b1);
    chk("ack_instr_kept", bus0.instr_o, exp_instr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          r;
    logic [7:0]  la;
    logic [31:0] ld;
    prog[0] = 32'h20010005;
    prog[1] = 32'h20020007;
    prog[2] = 32'h00221820;
    prog[3] = 32'hAC030000;
    rst = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0;
    bus0.req_i = 1'b0; bus0.addr_i = '0; bus0.ack_i = 1'b0;
    tick;

    // fill the whole store while in reset
    for (int i = 0; i < DEPTH; i++) begin
      load_we   = 1'b1;
      load_addr = 8'(i);
      load_data = (i < 4) ? prog[i] : $urandom;
      mem_m[i]  = load_data;
      tick;
    end
    load_we = 1'b0;

    chk("rst_ready", bus0.ready_o, 1'b1);
    chk("rst_valid", bus0.valid_o, 1'b0);
    chk("rst_err", bus0.err_o, 1'b0);
    chk("rst_instr", bus0.instr_o, 32'h0);

    // zero-latency instance: one response every two cycles, in address order
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick;
      chk("lat0_valid", bus1.valid_o, (k % 2 == 0));
      chk("lat0_ready", bus1.ready_o, (k % 2 == 1));
      if (k % 2 == 0) chk("lat0_instr", bus1.instr_o, mem_m[k / 2]);
      chk("idle_ready", bus0.ready_o, 1'b1);
    end

    // directed fetches
    fetch(32'h8, 0);
    chk("tp_instr_addr8", mem_m[2], 32'h00221820);
    fetch(32'h6, 0);
    fetch(32'h400, 0);
    fetch(32'hC, 5);

    // load write on the edge the fetch of 0x4 enters RESP
    bus0.req_i = 1'b1; bus0.addr_i = 32'h4; bus0.ack_i = 1'b0;
    tick;
    bus0.req_i = 1'b0;
    tick;
    chk("rbw_wait", bus0.valid_o, 1'b0);
    load_we = 1'b1; load_addr = 8'd1; load_data = 32'hDEADBEEF;
    tick;
    load_we = 1'b0;
    chk("rbw_valid", bus0.valid_o, 1'b1);
    chk("rbw_old", bus0.instr_o, 32'h20020007);
    mem_m[1] = 32'hDEADBEEF;
    bus0.ack_i = 1'b1;
    tick;
    bus0.ack_i = 1'b0;
    fetch(32'h4, 0);
    chk("rbw_new_model", mem_m[1], 32'hDEADBEEF);

    // reset while the fetch is in WAIT
    bus0.req_i = 1'b1; bus0.addr_i = 32'h0;
    tick;
    bus0.req_i = 1'b0;
    chk("rstw_busy", bus0.ready_o, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rstw_ready", bus0.ready_o, 1'b1);
    chk("rstw_valid", bus0.valid_o, 1'b0);
    chk("rstw_instr", bus0.instr_o, 32'h0);
    chk("rstw_err", bus0.err_o, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("rstw_no_valid", bus0.valid_o, 1'b0);
    end
    fetch(32'h0, 0);

    // randomized fetches with interleaved loads and ack stalls
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(2) == 0) begin
        la = 8'($urandom_range(DEPTH - 1));
        ld = $urandom;
        load_we = 1'b1; load_addr = la; load_data = ld;
        tick;
        load_we = 1'b0;
        mem_m[la] = ld;
      end
      r = $urandom_range(9);
      if (r < 7)       a = 32'($urandom_range(DEPTH - 1)) * 4;
      else if (r == 7) a = 32'($urandom_range(DEPTH - 1)) * 4 + 32'($urandom_range(3, 1));
      else             a = $urandom | 32'h0000_0400;
      fetch(a, $urandom_range(3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
